conv_stream_engine: RTL and testbench

Parametrised streaming 2-D convolution engine for the image-convolution processor. Accepts a raster-order pixel stream, holds K-1 line buffers and a KxK window, multiplies against a loadable signed kernel, and emits scaled, saturated output pixels for every fully covered window ("valid" convolution, no padding). It replaces the multi-instruction microcoded convolution loop with a hardwired datapath. It sits between data-RAM read and write sequencing, with kernel loads driven by the control unit.

---
 rtl/conv_stream_engine.sv | 195 +++++++++++++++++++
 tb/tb_conv_stream_engine.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_engine.sv
// Streaming KxK "valid" convolution: line buffers + window, registered products,
// then registered sum/shift/saturate. One stall signal freezes the whole pipeline.
//
// state   | meaning
// IDLE    | kernel writable, waiting for start
// RUN     | accepting raster pixels
// DRAIN   | input closed, flushing pipeline until last output leaves
// DONE    | one-cycle completion pulse
module conv_stream_engine #(
  parameter int K      = 3,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 8,
  parameter int KW     = 8,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       k_wr_en,
  input  logic [$clog2(K*K)-1:0]     k_wr_idx,
  input  logic signed [KW-1:0]       k_wr_data,
  input  logic                       start,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [DATA_W-1:0]          pix_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam int NC    = K * K;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW    = DATA_W + 1 + KW;
  localparam int ACC_W = DATA_W + KW + $clog2(NC) + 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic signed [KW-1:0]     coef_q [NC];
  logic signed [KW-1:0]     coef_d [NC];
  logic [DATA_W-1:0]        lb_q   [K-1][IMG_W];
  logic [DATA_W-1:0]        lb_d   [K-1][IMG_W];
  logic [DATA_W-1:0]        win_q  [NC];
  logic [DATA_W-1:0]        win_d  [NC];
  logic signed [PW-1:0]     prod_q [NC];
  logic signed [PW-1:0]     prod_d [NC];
  logic                     win_vld_q, win_vld_d, win_last_q, win_last_d;
  logic                     prod_vld_q, prod_vld_d, prod_last_q, prod_last_d;
  logic                     out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     advance, accept, frame_end, pipe_empty;
  logic signed [ACC_W-1:0]  acc, shifted;
  logic [OUT_W-1:0]         sat;

  assign advance    = !(out_valid_q && !out_ready);
  assign accept     = pix_valid && pix_ready;
  assign frame_end  = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign pipe_empty = !win_vld_q && !prod_vld_q && !out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && frame_end) state_d = S_DRAIN;
      S_DRAIN: if (pipe_empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pix_ready = (state_q == S_RUN) && advance;
    busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    done      = (state_q == S_DONE);
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    coef_d = coef_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        col_d = '0;
        row_d = '0;
      end
      if (k_wr_en && (int'(k_wr_idx) < NC)) coef_d[k_wr_idx] = k_wr_data;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Line buffer m delays the stream by (m+1) rows; its oldest entry feeds window row K-2-m.
  always_comb begin
    lb_d  = lb_q;
    win_d = win_q;
    if (accept) begin
      lb_d[0][0] = pix_data;
      for (int m = 1; m < K - 1; m++) lb_d[m][0] = lb_q[m-1][IMG_W-1];
      for (int m = 0; m < K - 1; m++)
        for (int j = 1; j < IMG_W; j++) lb_d[m][j] = lb_q[m][j-1];
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K - 1; c++) win_d[r*K+c] = win_q[r*K+c+1];
      win_d[NC-1] = pix_data;
      for (int r = 0; r < K - 1; r++) win_d[r*K+K-1] = lb_q[K-2-r][IMG_W-1];
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NC; i++) acc = acc + ACC_W'(prod_q[i]);
    shifted = acc >>> SHIFT;
    if (shifted[ACC_W-1])               sat = '0;
    else if (|shifted[ACC_W-1:OUT_W])   sat = '1;
    else                                sat = shifted[OUT_W-1:0];
  end

  always_comb begin
    win_vld_d   = win_vld_q;
    win_last_d  = win_last_q;
    prod_vld_d  = prod_vld_q;
    prod_last_d = prod_last_q;
    prod_d      = prod_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (advance) begin
      win_vld_d   = accept && (int'(row_q) >= K - 1) && (int'(col_q) >= K - 1);
      win_last_d  = accept && frame_end;
      prod_vld_d  = win_vld_q;
      prod_last_d = win_last_q;
      for (int i = 0; i < NC; i++)
        prod_d[i] = PW'($signed({1'b0, win_q[i]})) * PW'(coef_q[i]);
      out_valid_d = prod_vld_q;
      out_last_d  = prod_vld_q && prod_last_q;
      if (prod_vld_q) out_data_d = sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      for (int i = 0; i < NC; i++) coef_q[i] <= '0;
      win_vld_q   <= 1'b0;
      win_last_q  <= 1'b0;
      prod_vld_q  <= 1'b0;
      prod_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      coef_q      <= coef_d;
      win_vld_q   <= win_vld_d;
      win_last_q  <= win_last_d;
      prod_vld_q  <= prod_vld_d;
      prod_last_q <= prod_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Pixel storage is never reset; validity flags keep stale values out of results.
  always_ff @(posedge clk) begin
    lb_q   <= lb_d;
    win_q  <= win_d;
    prod_q <= prod_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed bench for conv_stream_engine (3x3 kernel, 5x4 image); a second
// instance with SHIFT=3 shares every input.
module tb_conv_stream_engine;
  localparam int NPIX = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              k_wr_en = 1'b0;
  logic [3:0]        k_wr_idx = '0;
  logic signed [7:0] k_wr_data = '0;
  logic              start = 1'b0;
  logic              pix_valid = 1'b0;
  logic [7:0]        pix_data = '0;
  logic              out_ready = 1'b1;

  logic       pix_ready, out_valid, out_last, busy, done;
  logic [7:0] out_data;
  logic       pix_ready_1, out_valid_1, out_last_1, busy_1, done_1;
  logic [7:0] out_data_1;

  int n_chk = 0;
  int n_pass = 0;
  int got0[$];
  int last0[$];
  int got1[$];
  int done_cnt;
  int exp0[6];

  always #5 clk = ~clk;

  conv_stream_engine #(.K(3), .IMG_W(5), .IMG_H(4), .DATA_W(8), .KW(8), .OUT_W(8), .SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .k_wr_en(k_wr_en), .k_wr_idx(k_wr_idx), .k_wr_data(k_wr_data),
    .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done));

  conv_stream_engine #(.K(3), .IMG_W(5), .IMG_H(4), .DATA_W(8), .KW(8), .OUT_W(8), .SHIFT(3)) dut_sh (
    .clk(clk), .rst_n(rst_n), .k_wr_en(k_wr_en), .k_wr_idx(k_wr_idx), .k_wr_data(k_wr_data),
    .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready_1), .pix_data(pix_data),
    .out_valid(out_valid_1), .out_ready(out_ready), .out_data(out_data_1), .out_last(out_last_1),
    .busy(busy_1), .done(done_1));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int pixval(input int pat, input int n);
    case (pat)
      0: return n;
      1: return 255;
      2: return 10;
      3: return 8;
      default: return (n + 1) % 256;
    endcase
  endfunction

  task automatic load_k(input int center, input int others);
    for (int i = 0; i < 9; i++) begin
      k_wr_en   = 1'b1;
      k_wr_idx  = 4'(i);
      k_wr_data = 8'((i == 4) ? center : others);
      @(posedge clk); #1;
    end
    k_wr_en = 1'b0;
  endtask

  // bp: stall out_ready for 5 cycles once the first output has left.
  // inj: pulse start and a kernel write mid-frame. abort_at: assert reset after that many pixels.
  task automatic run_frame(input int pat, input bit bp, input bit inj, input int abort_at);
    int  n = 0;
    int  stall = 0;
    int  post = -1;
    bit  injd = 1'b0;
    bit  fin = 1'b0;
    got0.delete(); last0.delete(); got1.delete();
    done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_up", busy, 1);
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      pix_valid = (n < NPIX);
      pix_data  = 8'(pixval(pat, n));
      out_ready = (stall == 0);
      if (abort_at > 0 && n == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pix_valid = 1'b0;
        return;
      end
      if (inj && !injd && n == 3) begin
        start = 1'b1; k_wr_en = 1'b1; k_wr_idx = 4'd4; k_wr_data = 8'sd5;
        injd = 1'b1;
      end
      @(negedge clk);
      if (stall > 0) begin
        chk("bp_hold_data", out_data, 7);
        chk("bp_pix_ready", pix_ready, 0);
        stall--;
      end
      if (pix_valid && pix_ready) n++;
      if (out_valid && out_ready) begin
        got0.push_back(int'(out_data));
        last0.push_back(int'(out_last));
        if (bp && got0.size() == 1) stall = 5;
      end
      if (out_valid_1 && out_ready) got1.push_back(int'(out_data_1));
      if (done) begin
        done_cnt++;
        post = 3;
      end else if (post > 0) begin
        post--;
      end
      if (post == 0) fin = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k_wr_en = 1'b0;
    end
    pix_valid = 1'b0;
    out_ready = 1'b1;
    chk("frame_completed", int'(fin), 1);
    chk("busy_after", busy, 0);
  endtask

  task automatic check_frame(input string tag, input int e1);
    chk({tag, "_count"}, got0.size(), 6);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s_out%0d", tag, i), (i < got0.size()) ? got0[i] : -1, exp0[i]);
      chk($sformatf("%s_last%0d", tag, i), (i < last0.size()) ? last0[i] : -1, (i == 5) ? 1 : 0);
    end
    if (e1 >= 0) begin
      chk({tag, "_sh_count"}, got1.size(), 6);
      for (int i = 0; i < 6; i++)
        chk($sformatf("%s_sh_out%0d", tag, i), (i < got1.size()) ? got1[i] : -1, e1);
    end
  endtask

  initial begin
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pix_ready", pix_ready, 0);
    chk("reset_out_data", out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    load_k(1, 0);
    run_frame(0, 1'b0, 1'b0, 0);
    exp0 = '{6, 7, 8, 11, 12, 13};
    check_frame("identity", -1);

    load_k(1, 1);
    run_frame(1, 1'b0, 1'b0, 0);
    exp0 = '{255, 255, 255, 255, 255, 255};
    check_frame("sat_pos", -1);

    load_k(-1, 0);
    run_frame(2, 1'b0, 1'b0, 0);
    exp0 = '{0, 0, 0, 0, 0, 0};
    check_frame("clamp_neg", -1);

    load_k(1, 0);
    run_frame(0, 1'b1, 1'b0, 0);
    exp0 = '{6, 7, 8, 11, 12, 13};
    check_frame("backpressure", -1);

    run_frame(0, 1'b0, 1'b1, 0);
    check_frame("ignored_cmds", -1);

    run_frame(0, 1'b0, 1'b0, 7);
    @(posedge clk); #1;
    run_frame(4, 1'b0, 1'b0, 0);
    exp0 = '{0, 0, 0, 0, 0, 0};
    check_frame("after_reset", -1);

    load_k(1, 1);
    run_frame(3, 1'b0, 1'b0, 0);
    exp0 = '{72, 72, 72, 72, 72, 72};
    check_frame("shift", 9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
